// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipelined CPU front end:
//   - fetch_state_e   : instruction fetch FSM states
//   - NOP_INSTR       : bubble inserted when no valid instruction is presented
//   - DEFAULT_RESET_PC: default first fetch address after reset
//   - align_word()    : forces a byte address onto a 32-bit word boundary
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if
//   Request/acknowledge bus between the fetch unit and instruction memory.
//   - imem_req   : fetch request (master -> slave)
//   - imem_addr  : word-aligned fetch address (master -> slave)
//   - imem_ack   : one-cycle pulse, imem_rdata valid (slave -> master)
//   - imem_rdata : fetched word (slave -> master)
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// pc_register
//   Program counter with asynchronous active-low reset to RESET_PC.
//   - clk, rst_n : clock, async active-low reset
//   - load       : take target (has priority over inc)
//   - inc        : advance by one word (+4)
//   - target     : load value (already word aligned by the caller)
//   - pc         : current program counter
module pc_register
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = target;
    else if (inc) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: owns the PC, runs the req/ack handshake to instruction memory
//   and presents one instruction at a time to IF/ID, with NOP bubbles otherwise.
//   - clk, rst_n                   : clock, async active-low reset
//   - cpu_en                       : global enable for consumption and redirects
//   - id_shouldStall               : IF/ID holding, presented instruction not consumed
//   - id_/ex_shouldJumpOrBranch    : redirect requests (EX has priority)
//   - id_/ex_target                : redirect targets
//   - imem                         : instruction memory bus (master side)
//   - if_pc_4                      : PC of the presented instruction + 4
//   - if_instruction, if_valid     : presented instruction / validity
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_en,
  input  logic                            id_shouldStall,
  input  logic                            id_shouldJumpOrBranch,
  input  logic [31:0]                     id_target,
  input  logic                            ex_shouldJumpOrBranch,
  input  logic [31:0]                     ex_target,
  instruction_fetch_unit_if.master        imem,
  output logic [31:0]                     if_pc_4,
  output logic [31:0]                     if_instruction,
  output logic                            if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  pc;
  logic         pc_load, pc_inc;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic         req;
  logic [31:0]  addr;

  assign redirect        = cpu_en && (ex_shouldJumpOrBranch || id_shouldJumpOrBranch);
  assign redirect_target = align_word(ex_shouldJumpOrBranch ? ex_target : id_target);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (redirect_target),
    .pc     (pc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Holding register and abandoned-request address only matter in HOLD/DRAIN,
  // which are unreachable without first loading them, so no reset is needed.
  always_ff @(posedge clk) begin
    hold_q       <= hold_d;
    drain_addr_q <= drain_addr_d;
  end

  // Next state and PC/buffer control
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    drain_addr_d = drain_addr_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            // Word arrived for a path we are leaving: drop it, refetch at target.
            pc_load = 1'b1;
            state_d = ST_FETCH;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          // Request is already on the bus and must stay stable until acked,
          // so remember its address and finish it in DRAIN.
          pc_load      = 1'b1;
          drain_addr_d = pc;
          state_d      = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else if (cpu_en && !id_shouldStall) begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        pc_load = redirect;
        if (imem.imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req            = 1'b0;
    addr           = pc;
    if_valid       = 1'b0;
    if_instruction = NOP_INSTR;
    case (state_q)
      ST_FETCH: req = 1'b1;
      ST_HOLD: begin
        if_valid       = 1'b1;
        if_instruction = hold_q;
      end
      ST_DRAIN: begin
        req  = 1'b1;
        addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign if_pc_4        = pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en;
  logic        id_shouldStall;
  logic        id_shouldJumpOrBranch;
  logic [31:0] id_target;
  logic        ex_shouldJumpOrBranch;
  logic [31:0] ex_target;
  logic [31:0] if_pc_4;
  logic [31:0] if_instruction;
  logic        if_valid;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_fetch_unit_if imem_bus ();

  instruction_fetch_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cpu_en                (cpu_en),
    .id_shouldStall        (id_shouldStall),
    .id_shouldJumpOrBranch (id_shouldJumpOrBranch),
    .id_target             (id_target),
    .ex_shouldJumpOrBranch (ex_shouldJumpOrBranch),
    .ex_target             (ex_target),
    .imem                  (imem_bus.master),
    .if_pc_4               (if_pc_4),
    .if_instruction        (if_instruction),
    .if_valid              (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, stall, idj;
    logic [31:0] idt;
    logic        exj;
    logic [31:0] ext;
    logic        ack;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] einstr;
    logic [31:0] epc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic stall, logic idj, logic [31:0] idt,
                              logic exj, logic [31:0] ext, logic ack, logic [31:0] rd,
                              logic ereq, logic [31:0] eaddr, logic evld,
                              logic [31:0] einstr, logic [31:0] epc4);
    vec_t v;
    v.en = en; v.stall = stall; v.idj = idj; v.idt = idt; v.exj = exj; v.ext = ext;
    v.ack = ack; v.rd = rd; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld;
    v.einstr = einstr; v.epc4 = epc4;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic ereq, input logic [31:0] eaddr,
                         input logic evld, input logic [31:0] einstr, input logic [31:0] epc4);
    chk("imem_req", row, {31'b0, imem_bus.imem_req}, {31'b0, ereq});
    chk("imem_addr", row, imem_bus.imem_addr, eaddr);
    chk("if_valid", row, {31'b0, if_valid}, {31'b0, evld});
    chk("if_instruction", row, if_instruction, einstr);
    chk("if_pc_4", row, if_pc_4, epc4);
  endtask

  task automatic drive(input vec_t v);
    cpu_en                = v.en;
    id_shouldStall        = v.stall;
    id_shouldJumpOrBranch = v.idj;
    id_target             = v.idt;
    ex_shouldJumpOrBranch = v.exj;
    ex_target             = v.ext;
    imem_bus.imem_ack     = v.ack;
    imem_bus.imem_rdata   = v.rd;
  endtask

  localparam logic [31:0] A0 = 32'h0010_0093, A1 = 32'h0020_0113, A2 = 32'h0030_0193;
  localparam logic [31:0] B0 = 32'h0040_0213, C0 = 32'h0050_0293;

  initial begin
    // One row per cycle: inputs driven in that cycle, outputs expected in that cycle.
    //                   en stl idj idt     exj ext           ack rd            req addr        vld instr pc4
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, 32'hFFFF_FFFF, 0, 32'h0,       0, 32'h0, 32'h4));   // 0 IDLE, stray ack
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, A0,            1, 32'h0,       0, 32'h0, 32'h4));   // 1 FETCH 0
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h0,       1, A0,    32'h4));   // 2 HOLD
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, A1,            1, 32'h4,       0, 32'h0, 32'h8));   // 3 FETCH 4
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h4,       1, A1,    32'h8));   // 4
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, A2,            1, 32'h8,       0, 32'h0, 32'hC));   // 5 FETCH 8
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h8,       1, A2,    32'hC));   // 6 stall
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h8,       1, A2,    32'hC));   // 7 stall
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h8,       1, A2,    32'hC));   // 8 stall
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h8,       1, A2,    32'hC));   // 9 release
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 32'h100,      0, 32'h0,         1, 32'hC,       0, 32'h0, 32'h10));  // 10 FETCH C, EX redirect
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         1, 32'hC,       0, 32'h0, 32'h104)); // 11 DRAIN
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         1, 32'hC,       0, 32'h0, 32'h104)); // 12 DRAIN
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'hC,       0, 32'h0, 32'h104)); // 13 DRAIN ack discarded
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        1, B0,            1, 32'h100,     0, 32'h0, 32'h104)); // 14 FETCH 100
    vecs.push_back(mk(1, 0, 1, 32'h40, 1, 32'h80,       0, 32'h0,         0, 32'h100,     1, B0,    32'h104)); // 15 ID+EX redirect
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 32'h103,      1, 32'hBAD0_0BAD, 1, 32'h80,      0, 32'h0, 32'h84));  // 16 ack+redirect 0x103
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,        1, C0,            1, 32'h100,     0, 32'h0, 32'h104)); // 17 cpu_en=0 ack
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h200,      0, 32'h0,         0, 32'h100,     1, C0,    32'h104)); // 18 redirect ignored
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h100,     1, C0,    32'h104)); // 19
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         0, 32'h100,     1, C0,    32'h104)); // 20 consume
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,         1, 32'h104,     0, 32'h0, 32'h108)); // 21 FETCH 104

    rst_n = 1'b0;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    chk_all(-1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_all(i, vecs[i].ereq, vecs[i].eaddr, vecs[i].evld, vecs[i].einstr, vecs[i].epc4);
    end

    // Reset asserted while the FETCH of 0x104 is outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    chk_all(101, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    @(negedge clk);
    #1;
    chk_all(102, 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
